// File: rtl/multi_flop_data_sync.sv
// -----------------------------------------------------------------------------
// multi_flop_data_sync
//
// Receive-side clock-domain-crossing synchroniser for a multi-bit bus that is
// qualified by a single enable line. Only bus_enable passes through a
// NUM_STAGES flop chain. When the synchronised enable shows an event, the
// bus is captured into sync_bus. A one-cycle enable_pulse is emitted in the
// same cycle that the new sync_bus value first becomes visible.
//
// Parameters
//   BUS_WIDTH  : width of unsync_bus / sync_bus (1..64)
//   NUM_STAGES : synchroniser depth on bus_enable (2..4)
//   MODE       : 0 = level mode, where a rising edge of bus_enable is the event
//                1 = toggle mode, where any transition of bus_enable is the event
//
// Ports
//   CLK          in   destination-domain clock
//   RST          in   asynchronous, active-low reset
//   unsync_bus   in   source-domain data; the source must hold it stable from
//                     its enable event until enable_pulse
//   bus_enable   in   source-domain qualifier (level or toggle per MODE)
//   sync_bus     out  registered captured data; holds its value between events
//   enable_pulse out  single-cycle strobe marking new data on sync_bus
//   stab_err     out  sticky bus-stability error (only with DATA_SYNC_STAB_EN)
//
// Build option
//   DATA_SYNC_STAB_EN : when defined, adds a shadow register of the bus and
//                       the sticky stab_err output. This flags any change of
//                       unsync_bus while an enable event is still travelling
//                       through the chain.
// -----------------------------------------------------------------------------
module multi_flop_data_sync #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int MODE       = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse
`ifdef DATA_SYNC_STAB_EN
    ,
    output logic                 stab_err
`endif
);

    // -------------------------------------------------------------------------
    // Parameter legality: unsupported configurations stop elaboration.
    // -------------------------------------------------------------------------
    generate
        if (NUM_STAGES < 2 || NUM_STAGES > 4) begin : g_bad_stages
            $error("multi_flop_data_sync: NUM_STAGES must be in 2..4");
        end
        if (BUS_WIDTH < 1 || BUS_WIDTH > 64) begin : g_bad_width
            $error("multi_flop_data_sync: BUS_WIDTH must be in 1..64");
        end
        if (MODE != 0 && MODE != 1) begin : g_bad_mode
            $error("multi_flop_data_sync: MODE must be 0 or 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Enable synchroniser chain
    // -------------------------------------------------------------------------
    logic [NUM_STAGES-1:0] chain_reg;
    logic                  en_sync;
    logic                  pulse_ff;
    logic                  sync_event;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain_reg[0] <= 1'b0;
        end else begin
            chain_reg[0] <= bus_enable;
        end
    end

    generate
        for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_chain
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    chain_reg[gi] <= 1'b0;
                end else begin
                    chain_reg[gi] <= chain_reg[gi-1];
                end
            end
        end
    endgenerate

    assign en_sync = chain_reg[NUM_STAGES-1];

    // pulse_ff remembers the previous synchronised enable level. Because it
    // resets to 0, an enable that is already high at reset release produces
    // exactly one event in either mode.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pulse_ff <= 1'b0;
        end else begin
            pulse_ff <= en_sync;
        end
    end

    generate
        if (MODE == 0) begin : g_level_event
            assign sync_event = en_sync & ~pulse_ff;
        end else begin : g_toggle_event
            assign sync_event = en_sync ^ pulse_ff;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Registered outputs. Both outputs come straight from flops, so there is
    // no combinational path from an input to an output.
    // -------------------------------------------------------------------------
    logic [BUS_WIDTH-1:0] sync_bus_reg;
    logic [BUS_WIDTH-1:0] sync_bus_next;
    logic                 enable_pulse_reg;

    always_comb begin
        sync_bus_next = sync_bus_reg;
        if (sync_event) begin
            sync_bus_next = unsync_bus;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_bus_reg     <= '0;
            enable_pulse_reg <= 1'b0;
        end else begin
            sync_bus_reg     <= sync_bus_next;
            enable_pulse_reg <= sync_event;
        end
    end

    assign sync_bus     = sync_bus_reg;
    assign enable_pulse = enable_pulse_reg;

`ifdef DATA_SYNC_STAB_EN
    // -------------------------------------------------------------------------
    // Bus stability monitor. An event is in flight while any chain stage
    // disagrees with pulse_ff. During that window the bus should be frozen.
    // The check compares the bus against its value from one cycle earlier.
    // -------------------------------------------------------------------------
    logic [BUS_WIDTH-1:0] bus_q;
    logic                 stab_err_reg;
    logic                 stab_err_next;
    logic                 in_flight;

    assign in_flight = |(chain_reg ^ {NUM_STAGES{pulse_ff}});

    always_comb begin
        stab_err_next = stab_err_reg;
        if (in_flight && (unsync_bus != bus_q)) begin
            stab_err_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus_q        <= '0;
            stab_err_reg <= 1'b0;
        end else begin
            bus_q        <= unsync_bus;
            stab_err_reg <= stab_err_next;
        end
    end

    assign stab_err = stab_err_reg;
`endif

endmodule

// File: tb/tb_multi_flop_data_sync.sv
// -----------------------------------------------------------------------------
// tb_multi_flop_data_sync
//
// Scoreboard bench for five synchroniser configurations that share one clock
// and one reset:
//   k=0 MODE0 NS2 W8, k=1 MODE1 NS3 W8, k=2 MODE0 NS4 W64,
//   k=3 MODE0 NS4 W1, k=4 MODE0 NS2 W8 (stability-monitor target)
//
// Whenever the stimulus creates a source-side event, it pushes the expected
// arrival cycle and data into a per-instance queue. The arrival cycle is the
// sampling edge plus NUM_STAGES. A negedge monitor tracks what each output
// must show on every cycle: a pulse only on a due cycle, and otherwise
// sync_bus holding the last delivered value. The monitor compares this
// against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_multi_flop_data_sync;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  be;
    logic [63:0] ub [5];
    logic [4:0]  pulse;
    logic [4:0]  stab;
    logic [7:0]  sb0;
    logic [7:0]  sb1;
    logic [63:0] sb2;
    logic [0:0]  sb3;
    logic [7:0]  sb4;
    logic [63:0] sbw [5];

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [63:0] data;
    } exp_t;

    exp_t        q [5][$];
    logic [63:0] model_sync [5];
    int          checks = 0;
    int          passes = 0;

    // ---------------------------------------------------------------- DUTs
    multi_flop_data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .MODE(0)) u0 (
        .CLK(CLK), .RST(RST), .unsync_bus(ub[0][7:0]), .bus_enable(be[0]),
        .sync_bus(sb0), .enable_pulse(pulse[0])
`ifdef DATA_SYNC_STAB_EN
        , .stab_err(stab[0])
`endif
    );
    multi_flop_data_sync #(.BUS_WIDTH(8), .NUM_STAGES(3), .MODE(1)) u1 (
        .CLK(CLK), .RST(RST), .unsync_bus(ub[1][7:0]), .bus_enable(be[1]),
        .sync_bus(sb1), .enable_pulse(pulse[1])
`ifdef DATA_SYNC_STAB_EN
        , .stab_err(stab[1])
`endif
    );
    multi_flop_data_sync #(.BUS_WIDTH(64), .NUM_STAGES(4), .MODE(0)) u2 (
        .CLK(CLK), .RST(RST), .unsync_bus(ub[2]), .bus_enable(be[2]),
        .sync_bus(sb2), .enable_pulse(pulse[2])
`ifdef DATA_SYNC_STAB_EN
        , .stab_err(stab[2])
`endif
    );
    multi_flop_data_sync #(.BUS_WIDTH(1), .NUM_STAGES(4), .MODE(0)) u3 (
        .CLK(CLK), .RST(RST), .unsync_bus(ub[3][0:0]), .bus_enable(be[3]),
        .sync_bus(sb3), .enable_pulse(pulse[3])
`ifdef DATA_SYNC_STAB_EN
        , .stab_err(stab[3])
`endif
    );
    multi_flop_data_sync #(.BUS_WIDTH(8), .NUM_STAGES(2), .MODE(0)) u4 (
        .CLK(CLK), .RST(RST), .unsync_bus(ub[4][7:0]), .bus_enable(be[4]),
        .sync_bus(sb4), .enable_pulse(pulse[4])
`ifdef DATA_SYNC_STAB_EN
        , .stab_err(stab[4])
`endif
    );

`ifndef DATA_SYNC_STAB_EN
    assign stab = '0;
`endif

    assign sbw[0] = {56'd0, sb0};
    assign sbw[1] = {56'd0, sb1};
    assign sbw[2] = sb2;
    assign sbw[3] = {63'd0, sb3};
    assign sbw[4] = {56'd0, sb4};

    // ------------------------------------------------------ configuration
    function automatic int ns_of(int k);
        case (k)
            1:       return 3;
            2, 3:    return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int mode_of(int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic logic [63:0] mask_of(int k);
        logic [63:0] one;
        one = 64'd1;
        case (k)
            2:       return '1;
            3:       return one;
            default: return (one << 8) - one;
        endcase
    endfunction

    // ------------------------------------------------------------- helpers
    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Source-side event: present the data and create the enable event
    // together. The next edge samples it, and the result arrives NUM_STAGES
    // edges later.
    task automatic ev(int k, logic [63:0] d);
        exp_t e;
        ub[k] = d & mask_of(k);
        if (mode_of(k) == 0) be[k] = 1'b1;
        else                 be[k] = ~be[k];
        e.due  = cyc + 1 + ns_of(k);
        e.data = d & mask_of(k);
        q[k].push_back(e);
    endtask

    task automatic run_rand(int k, int n);
        for (int i = 0; i < n; i++) begin
            int idle;
            idle = $urandom_range(1, 4);
            // Nothing is in flight here, so bus noise must not leak through.
            for (int j = 0; j < idle; j++) begin
                ub[k] = {$urandom, $urandom} & mask_of(k);
                wait_cyc(1);
            end
            ev(k, {$urandom, $urandom});
            if (mode_of(k) == 0) begin
                int hi;
                hi = $urandom_range(1, 6);
                wait_cyc(hi);
                be[k] = 1'b0;
                if (hi < ns_of(k) + 2) wait_cyc(ns_of(k) + 2 - hi);
            end else begin
                wait_cyc($urandom_range(ns_of(k) + 2, ns_of(k) + 5));
            end
        end
    endtask

    // ------------------------------------------------------------- monitor
    always @(negedge CLK) begin
        for (int k = 0; k < 5; k++) begin
            logic exp_p;
            exp_p = 1'b0;
            if (!RST) begin
                model_sync[k] = '0;
            end else if (q[k].size() > 0 && q[k][0].due == cyc) begin
                exp_p = 1'b1;
                model_sync[k] = q[k][0].data;
                void'(q[k].pop_front());
            end
            check($sformatf("pulse[%0d] cyc %0d", k, cyc), {63'd0, pulse[k]}, {63'd0, exp_p});
            check($sformatf("sync_bus[%0d] cyc %0d", k, cyc), sbw[k], model_sync[k]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        RST = 1'b0;
        be  = '0;
        for (int k = 0; k < 5; k++) begin
            ub[k] = '0;
            model_sync[k] = '0;
        end
        repeat (3) @(posedge CLK);
        #1;
        check("reset stab", {59'd0, stab}, 64'd0);
        RST = 1'b1;
        wait_cyc(2);

        // Directed captures
        fork
            begin
                ev(0, 64'hA5);   wait_cyc(10); be[0] = 1'b0; wait_cyc(2);
                ev(0, 64'h3C);   wait_cyc(4);  be[0] = 1'b0; ub[0] = 64'hFF;
                wait_cyc(6);
            end
            begin
                ev(1, 64'h01); wait_cyc(5); ev(1, 64'h02); wait_cyc(5);
                ev(1, 64'h04); wait_cyc(5); ev(1, 64'h08); wait_cyc(5);
            end
            begin
                ev(2, 64'hDEADBEEFCAFEF00D); wait_cyc(8); be[2] = 1'b0; wait_cyc(2);
            end
            begin
                ev(3, 64'h1); wait_cyc(8); be[3] = 1'b0; wait_cyc(2);
                ev(3, 64'h0); wait_cyc(8); be[3] = 1'b0; wait_cyc(2);
            end
        join

        // The bus changes while the enable is steady and nothing is in flight.
        // Then it changes again one cycle after an enable rise.
        ub[4] = 64'h11; wait_cyc(3);
        ub[4] = 64'h33; wait_cyc(3);
`ifdef DATA_SYNC_STAB_EN
        check("stab quiet change", {63'd0, stab[4]}, 64'd0);
`endif
        ub[4] = 64'h11; wait_cyc(1);
        ev(4, 64'h11);
        wait_cyc(1);
        begin
            exp_t e;
            ub[4] = 64'h22;
            e = q[4].pop_back();
            e.data = 64'h22;
            q[4].push_back(e);
        end
        wait_cyc(1);
`ifdef DATA_SYNC_STAB_EN
        check("stab set", {63'd0, stab[4]}, 64'd1);
`endif
        wait_cyc(2); be[4] = 1'b0; wait_cyc(6);
`ifdef DATA_SYNC_STAB_EN
        check("stab sticky", {63'd0, stab[4]}, 64'd1);
`endif

        // Randomised traffic on all main instances in parallel
        fork
            run_rand(0, 12);
            run_rand(1, 12);
            run_rand(2, 12);
            run_rand(3, 12);
        join
        wait_cyc(4);

        // Reset one cycle before a pulse is due: the in-flight event must vanish
        ev(0, {$urandom, $urandom});
        wait_cyc(ns_of(0));
        RST = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("async clear pulse[%0d]", k), {63'd0, pulse[k]}, 64'd0);
            check($sformatf("async clear bus[%0d]", k), sbw[k], 64'd0);
            q[k].delete();
        end
        check("async clear stab", {59'd0, stab}, 64'd0);
        be = '0;
        wait_cyc(3);
        RST = 1'b1;
        wait_cyc(8);

        // Reset released with every enable already high: one event each
        RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            be[k] = 1'b1;
            ub[k] = {$urandom, $urandom} & mask_of(k);
        end
        wait_cyc(2);
        RST = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            e.due  = cyc + 1 + ns_of(k);
            e.data = ub[k];
            q[k].push_back(e);
        end
        wait_cyc(10);

        for (int k = 0; k < 5; k++) begin
            check($sformatf("drain[%0d]", k), 64'(q[k].size()), 64'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multi_flop_data_sync.md
Name: multi_flop_data_sync

Overview:
- Parametrised clock-domain-crossing synchroniser for a multi-bit bus qualified by a single enable line.
- Only the enable passes through a NUM_STAGES flop chain. The bus itself is captured in the destination domain once the synchronised enable shows an event, and a one-cycle enable_pulse is emitted with it.
- Sits on the receive side of every data crossing between the system and peripheral clock domains. It is the successor to the fixed 5-bit, 2-stage bit synchroniser.

Parameters:
- BUS_WIDTH, 8, width of unsync_bus / sync_bus; legal range 1..64.
- NUM_STAGES, 2, synchroniser flops on bus_enable; legal range 2..4. Other values are unsupported, and RTL stops elaboration with an error.
- MODE, 0, event definition. 0 = level mode: bus_enable rising edge is the event. 1 = toggle mode: any bus_enable transition is the event.

Ports:
- CLK  input  1  destination-domain clock
- RST  input  1  asynchronous, active-low reset
- unsync_bus  input  BUS_WIDTH  source-domain data; must be stable from the source-side enable event until enable_pulse
- bus_enable  input  1  source-domain qualifier (level or toggle per MODE)
- sync_bus  output  BUS_WIDTH  registered captured data; holds its value between events
- enable_pulse  output  1  single-cycle strobe, high in the cycle sync_bus is first valid with new data
- stab_err  output  1  sticky bus-stability error; present only with DATA_SYNC_STAB_EN

Behaviour:
- Reset is asserted asynchronously when RST=0 and released synchronously to CLK. On reset, all of the following clear to 0:
  - sync chain and the edge-detect flop pulse_ff
  - sync_bus and enable_pulse
  - stab_err and its shadow register bus_q, when present
- Sync chain:
  - chain[0] <= bus_enable; chain[i] <= chain[i-1].
  - en_sync = chain[NUM_STAGES-1]; pulse_ff <= en_sync.
- Event (combinational):
  - MODE=0: en_sync & ~pulse_ff
  - MODE=1: en_sync ^ pulse_ff
- Registered outputs:
  - enable_pulse <= event.
  - sync_bus <= event ? unsync_bus : sync_bus.
  - No combinational path from any input to any output.
- Latency:
  - bus_enable change sampled at CLK edge 0 -> enable_pulse and new sync_bus visible after edge NUM_STAGES; enable_pulse drops after edge NUM_STAGES+1.
  - NUM_STAGES=2: strobe after the 3rd edge counting the sampling edge.
- Pulse width is always exactly 1 CLK cycle, regardless of how long bus_enable stays high (MODE=0).
- Back-to-back events:
  - MODE=0 needs bus_enable low for at least 1 destination cycle between highs. A shorter low gap may be merged or missed, with no error indication.
  - MODE=1: every transition separated by at least 1 destination cycle yields exactly one pulse.
- Reset mid-operation: in-flight events are discarded and no pulse is produced for them. After release, a bus_enable already high produces one event in MODE=0 (pulse_ff starts at 0), and likewise in MODE=1.
- sync_bus never changes except in the cycle enable_pulse=1, or on reset.

Optional Feature:
- Macro: DATA_SYNC_STAB_EN.
- Defined:
  - Adds bus_q <= unsync_bus each cycle and the stab_err output.
  - In flight = any of chain[0..NUM_STAGES-1] differs from pulse_ff.
  - If in flight and unsync_bus != bus_q, set stab_err=1 at the next edge.
  - stab_err is sticky; it clears only on reset.
- Undefined: no bus_q, no stab_err port, no extra logic.

Test Plan:
- MODE=0, NUM_STAGES=2, BUS_WIDTH=8: drive unsync_bus=0xA5, raise bus_enable before edge 0 and hold 10 cycles -> enable_pulse high for exactly one cycle after edge 2; sync_bus=0xA5 from then on.
- MODE=0: event with 0x3C, lower bus_enable, change unsync_bus to 0xFF -> sync_bus stays 0x3C; no pulse.
- MODE=1, NUM_STAGES=3: toggle bus_enable 4 times, 5 cycles apart, with data 0x01, 0x02, 0x04, 0x08 -> 4 pulses, each 4 edges after its toggle; sync_bus follows in order.
- Assert RST with one cycle left before a pulse -> outputs 0 immediately, no pulse after release while bus_enable stays low. Release with bus_enable already high (MODE=0) -> one pulse NUM_STAGES+1 edges after release.
- DATA_SYNC_STAB_EN: change unsync_bus 0x11->0x22 one cycle after bus_enable rises -> stab_err=1 and stays 1 until RST. The same change made with no event in flight -> stab_err stays 0.
- BUS_WIDTH=1 and 64, NUM_STAGES=4 -> correct capture with latency 5 edges; all bits transferred (0xDEADBEEFCAFEF00D for 64).
